// File: rtl/spi_cmd_pkg.sv
// spi_cmd_pkg: shared states and opcode decode for the SPI command sequencer
package spi_cmd_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        WR,
        RD_FETCH,
        RD_WAIT,
        RD_HOLD,
        DISCARD
    } state_e;

    localparam int OP_RW_BIT = 7;

    function automatic logic is_read(input logic [7:0] op);
        return op[OP_RW_BIT];
    endfunction

endpackage

// File: rtl/spi_cmd_ctrl.sv
// spi_cmd_ctrl: turns SPI chip-select frames into register-file read/write bursts
module spi_cmd_ctrl
    import spi_cmd_pkg::*;
#(
    parameter int          ADDR_W      = 7,
    parameter int          NUM_REGS    = 96,
    parameter logic [7:0]  STATUS_BYTE = 8'hA5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              frame_start,
    input  logic              frame_end,
    input  logic              rx_valid,
    input  logic [7:0]        rx_byte,
    input  logic              tx_req,
    output logic [7:0]        tx_byte,
    output logic              reg_we,
    output logic              reg_re,
    output logic [ADDR_W-1:0] reg_addr,
    output logic [7:0]        reg_wdata,
    input  logic [7:0]        reg_rdata,
    output logic              busy,
    output logic [7:0]        err_cnt
);

    state_e            state, state_n;
    logic [ADDR_W-1:0] addr, addr_n, op_addr, addr_inc, reg_addr_n;
    logic [7:0]        tx_n, wdata_n;
    logic              we_n, re_n, err_inc;

    assign op_addr  = rx_byte[ADDR_W-1:0];
    assign addr_inc = (32'(addr) == NUM_REGS - 1) ? '0 : addr + ADDR_W'(1);
    assign busy     = state != IDLE;

    // Next-state, address, prefetch and strobe decode; frame edges override the per-state result
    always_comb begin
        state_n    = state;
        addr_n     = addr;
        tx_n       = tx_byte;
        wdata_n    = reg_wdata;
        reg_addr_n = reg_addr;
        we_n       = 1'b0;
        err_inc    = 1'b0;
        case (state)
            IDLE: if (frame_start) state_n = CMD;
            CMD: if (rx_valid) begin
                if (32'(op_addr) >= NUM_REGS) begin
                    state_n = DISCARD;
                    err_inc = 1'b1;
                end else begin
                    addr_n  = op_addr;
                    state_n = is_read(rx_byte) ? RD_FETCH : WR;
                end
            end
            WR: if (rx_valid) begin
                we_n       = 1'b1;
                reg_addr_n = addr;
                wdata_n    = rx_byte;
                addr_n     = addr_inc;
            end
            RD_FETCH: begin
                err_inc = tx_req;
                state_n = RD_WAIT;
            end
            RD_WAIT: begin
                err_inc = tx_req;
                tx_n    = reg_rdata;
                addr_n  = addr_inc;
                state_n = RD_HOLD;
            end
            RD_HOLD: if (tx_req) state_n = RD_FETCH;
            default: ;
        endcase
        if (frame_end) begin
            state_n = IDLE;
            tx_n    = STATUS_BYTE;
            addr_n  = '0;
        end else if (frame_start && state != IDLE) begin
            state_n = CMD;
            tx_n    = STATUS_BYTE;
            addr_n  = '0;
            err_inc = 1'b1;
        end
        re_n = state_n == RD_FETCH;
        if (re_n) reg_addr_n = addr_n;
    end

    // State, datapath and registered strobes; reg_re is high for the whole RD_FETCH cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            addr      <= '0;
            tx_byte   <= STATUS_BYTE;
            reg_we    <= 1'b0;
            reg_re    <= 1'b0;
            reg_addr  <= '0;
            reg_wdata <= '0;
            err_cnt   <= '0;
        end else begin
            state     <= state_n;
            addr      <= addr_n;
            tx_byte   <= tx_n;
            reg_we    <= we_n;
            reg_re    <= re_n;
            reg_addr  <= reg_addr_n;
            reg_wdata <= wdata_n;
            err_cnt   <= (err_inc && err_cnt != 8'hFF) ? err_cnt + 8'd1 : err_cnt;
        end
    end

endmodule

// File: tb/tb_spi_cmd_ctrl.sv
// tb_spi_cmd_ctrl: randomized self-checking bench with a register-file and transaction model
module tb_spi_cmd_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       frame_start = 1'b0;
    logic       frame_end = 1'b0;
    logic       rx_valid = 1'b0;
    logic [7:0] rx_byte = 8'h00;
    logic       tx_req = 1'b0;
    logic [7:0] reg_rdata = 8'h00;
    logic [7:0] tx_byte;
    logic       reg_we;
    logic       reg_re;
    logic [6:0] reg_addr;
    logic [7:0] reg_wdata;
    logic       busy;
    logic [7:0] err_cnt;

    int checks = 0;
    int errors = 0;
    int exp_err = 0;
    int we_cnt = 0;
    int re_cnt = 0;
    bit overlap = 1'b0;
    logic [7:0]  mem [96];
    logic [15:0] wq [$];
    int          rq [$];

    spi_cmd_ctrl dut (
        .clk(clk), .rst_n(rst_n), .frame_start(frame_start), .frame_end(frame_end),
        .rx_valid(rx_valid), .rx_byte(rx_byte), .tx_req(tx_req), .tx_byte(tx_byte),
        .reg_we(reg_we), .reg_re(reg_re), .reg_addr(reg_addr), .reg_wdata(reg_wdata),
        .reg_rdata(reg_rdata), .busy(busy), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    // Register-file model: logs strobes, applies writes, returns read data for the next cycle
    always @(negedge clk) begin
        if (reg_we && reg_re) overlap = 1'b1;
        if (reg_we) begin
            wq.push_back({1'b0, reg_addr, reg_wdata});
            we_cnt++;
            if (int'(reg_addr) < 96) mem[reg_addr] = reg_wdata;
        end
        if (reg_re) begin
            rq.push_back(int'(reg_addr));
            re_cnt++;
            reg_rdata = (int'(reg_addr) < 96) ? mem[reg_addr] : 8'hXX;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_frame();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        tick();
    endtask

    task automatic end_frame();
        frame_end = 1'b1;
        tick();
        frame_end = 1'b0;
        tick();
    endtask

    task automatic send(input logic [7:0] b);
        rx_byte  = b;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        checks++; if (tx_byte !== 8'hA5) begin errors++; $display("FAIL reset_tx got %h exp a5", tx_byte); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
        checks++; if ({reg_we, reg_re} !== 2'b00) begin errors++; $display("FAIL reset_strobes got %b exp 00", {reg_we, reg_re}); end
        checks++; if ({reg_addr, reg_wdata, err_cnt} !== 23'd0) begin errors++; $display("FAIL reset_regs got %h/%h/%h exp 0", reg_addr, reg_wdata, err_cnt); end
        rst_n = 1'b1;
        tick();
    endtask

    // Writes at start a, n bytes; it==0 is the fixed burst (5: 11,22,33), it==1 the wrap case (95 -> 0)
    task automatic test_write();
        for (int it = 0; it < 6; it++) begin
            int a = (it == 0) ? 5 : (it == 1) ? 95 : int'($urandom_range(0, 95));
            int n = (it == 0) ? 3 : (it == 1) ? 2 : int'($urandom_range(1, 5));
            logic [15:0] eq [$];
            wq.delete();
            rq.delete();
            start_frame();
            send(8'(a));
            for (int i = 0; i < n; i++) begin
                logic [7:0] d = (it == 0) ? 8'(8'h11 * (i + 1)) : 8'($urandom);
                send(d);
                eq.push_back({1'b0, 7'((a + i) % 96), d});
            end
            end_frame();
            checks++; if (wq.size() != eq.size()) begin errors++; $display("FAIL write_count it%0d got %0d exp %0d", it, wq.size(), eq.size()); end
            for (int i = 0; i < eq.size() && i < wq.size(); i++) begin
                checks++; if (wq[i] !== eq[i]) begin errors++; $display("FAIL write_data it%0d #%0d got %h exp %h", it, i, wq[i], eq[i]); end
            end
            checks++; if (rq.size() != 0) begin errors++; $display("FAIL write_no_read got %0d reads exp 0", rq.size()); end
            checks++; if (err_cnt !== 8'(exp_err)) begin errors++; $display("FAIL write_err got %0d exp %0d", err_cnt, exp_err); end
        end
    endtask

    // Read burst with prefetch; it==0 is the fixed case regs[10..12] = C0,C1,C2
    task automatic test_read();
        for (int it = 0; it < 5; it++) begin
            int a = (it == 0) ? 10 : int'($urandom_range(0, 95));
            int n = (it == 0) ? 3 : int'($urandom_range(1, 4));
            logic [7:0] ex [$];
            for (int i = 0; i < n; i++) begin
                mem[(a + i) % 96] = (it == 0) ? 8'(8'hC0 + i) : 8'($urandom_range(0, 255));
                ex.push_back(mem[(a + i) % 96]);
            end
            wq.delete();
            rq.delete();
            start_frame();
            rx_byte  = 8'h80 | 8'(a);
            rx_valid = 1'b1;
            tick();
            rx_valid = 1'b0;
            tick();
            checks++; if (tx_byte !== 8'hA5) begin errors++; $display("FAIL read_latency_early got %h exp a5", tx_byte); end
            tick();
            for (int i = 0; i < n; i++) begin
                checks++; if (tx_byte !== ex[i]) begin errors++; $display("FAIL read_tx it%0d #%0d got %h exp %h", it, i, tx_byte, ex[i]); end
                send(8'($urandom));
                if (i < n - 1) begin
                    tx_req = 1'b1;
                    tick();
                    tx_req = 1'b0;
                    tick();
                    tick();
                    tick();
                end
            end
            end_frame();
            checks++; if (rq.size() != n) begin errors++; $display("FAIL read_count it%0d got %0d exp %0d", it, rq.size(), n); end
            for (int i = 0; i < n && i < rq.size(); i++) begin
                checks++; if (rq[i] != (a + i) % 96) begin errors++; $display("FAIL read_addr it%0d #%0d got %0d exp %0d", it, i, rq[i], (a + i) % 96); end
            end
            checks++; if (wq.size() != 0) begin errors++; $display("FAIL read_no_write got %0d writes exp 0", wq.size()); end
            checks++; if ({busy, tx_byte} !== 9'h0A5) begin errors++; $display("FAIL read_end got busy %b tx %h exp 0/a5", busy, tx_byte); end
            checks++; if (err_cnt !== 8'(exp_err)) begin errors++; $display("FAIL read_err got %0d exp %0d", err_cnt, exp_err); end
        end
    endtask

    task automatic test_illegal();
        for (int it = 0; it < 3; it++) begin
            logic [7:0] op = (it == 0) ? 8'h70 : 8'($urandom_range(96, 127)) | (8'($urandom_range(0, 1)) << 7);
            int w0 = we_cnt;
            int r0 = re_cnt;
            start_frame();
            send(op);
            exp_err++;
            send(8'($urandom));
            tx_req = 1'b1;
            tick();
            tx_req = 1'b0;
            send(8'($urandom));
            checks++; if (busy !== 1'b1) begin errors++; $display("FAIL illegal_busy op %h got %b exp 1", op, busy); end
            end_frame();
            checks++; if (busy !== 1'b0) begin errors++; $display("FAIL illegal_idle got %b exp 0", busy); end
            checks++; if (we_cnt != w0 || re_cnt != r0) begin errors++; $display("FAIL illegal_strobes got %0d/%0d exp 0/0", we_cnt - w0, re_cnt - r0); end
            checks++; if (err_cnt !== 8'(exp_err)) begin errors++; $display("FAIL illegal_err got %0d exp %0d", err_cnt, exp_err); end
        end
    endtask

    task automatic test_abort();
        int a = int'($urandom_range(2, 94));
        logic [7:0] d = 8'($urandom);
        wq.delete();
        start_frame();
        send(8'(a));
        send(d);
        start_frame();
        exp_err++;
        send(8'h01);
        send(8'hAA);
        end_frame();
        checks++; if (wq.size() != 2 || wq[0] !== {1'b0, 7'(a), d} || wq[1] !== 16'h01AA) begin errors++; $display("FAIL abort_writes got %0d writes first %h exp 2 with %h,01aa", wq.size(), wq.size() > 0 ? wq[0] : 16'hxxxx, {1'b0, 7'(a), d}); end
        checks++; if (mem[a] !== d || mem[1] !== 8'hAA) begin errors++; $display("FAIL abort_mem got %h/%h exp %h/aa", mem[a], mem[1], d); end
        checks++; if (err_cnt !== 8'(exp_err)) begin errors++; $display("FAIL abort_err got %0d exp %0d", err_cnt, exp_err); end
    endtask

    task automatic test_underrun();
        int a = int'($urandom_range(0, 95));
        start_frame();
        rx_byte  = 8'h80 | 8'(a);
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
        tx_req   = 1'b1;
        tick();
        tx_req   = 1'b0;
        exp_err++;
        tick();
        checks++; if (err_cnt !== 8'(exp_err)) begin errors++; $display("FAIL underrun_err got %0d exp %0d", err_cnt, exp_err); end
        checks++; if (tx_byte !== mem[a]) begin errors++; $display("FAIL underrun_fetch got %h exp %h", tx_byte, mem[a]); end
        end_frame();
    endtask

    task automatic test_frame_edges();
        int a = int'($urandom_range(0, 95));
        logic [7:0] d = 8'($urandom);
        wq.delete();
        start_frame();
        send(8'(a));
        rx_byte   = d;
        rx_valid  = 1'b1;
        frame_end = 1'b1;
        tick();
        rx_valid  = 1'b0;
        frame_end = 1'b0;
        tick();
        checks++; if (wq.size() != 1 || wq[0] !== {1'b0, 7'(a), d}) begin errors++; $display("FAIL same_cycle_write got %0d writes exp 1 of %h", wq.size(), {1'b0, 7'(a), d}); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL same_cycle_idle got %b exp 0", busy); end
        start_frame();
        send(8'(a));
        frame_start = 1'b1;
        frame_end   = 1'b1;
        tick();
        frame_start = 1'b0;
        frame_end   = 1'b0;
        tick();
        checks++; if ({busy, err_cnt} !== {1'b0, 8'(exp_err)}) begin errors++; $display("FAIL end_priority got busy %b err %0d exp 0/%0d", busy, err_cnt, exp_err); end
    endtask

    task automatic test_reset_mid();
        int a = int'($urandom_range(0, 95));
        int w0, r0;
        mem[a] = 8'h3C;
        start_frame();
        rx_byte  = 8'h80 | 8'(a);
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
        tick();
        tick();
        checks++; if (tx_byte !== 8'h3C) begin errors++; $display("FAIL pre_reset_tx got %h exp 3c", tx_byte); end
        tx_req = 1'b1;
        rst_n  = 1'b0;
        #1;
        w0 = we_cnt;
        r0 = re_cnt;
        checks++; if ({tx_byte, busy, err_cnt, reg_re, reg_we} !== {8'hA5, 1'b0, 8'h00, 2'b00}) begin errors++; $display("FAIL mid_reset got tx %h busy %b err %0d re %b we %b exp a5/0/0/0/0", tx_byte, busy, err_cnt, reg_re, reg_we); end
        tx_req = 1'b0;
        send(8'h00);
        send(8'h12);
        checks++; if (we_cnt != w0 || re_cnt != r0 || busy !== 1'b0) begin errors++; $display("FAIL reset_quiet got %0d/%0d strobes busy %b exp 0/0/0", we_cnt - w0, re_cnt - r0, busy); end
        rst_n = 1'b1;
        exp_err = 0;
        tick();
    endtask

    task automatic test_saturate();
        for (int i = 0; i < 258; i++) begin
            frame_start = 1'b1;
            tick();
            frame_start = 1'b0;
            rx_byte  = 8'($urandom_range(96, 127));
            rx_valid = 1'b1;
            tick();
            rx_valid = 1'b0;
            end_frame();
            exp_err = (exp_err < 255) ? exp_err + 1 : 255;
            if (i == 253 || i == 257) begin
                checks++; if (err_cnt !== 8'(exp_err)) begin errors++; $display("FAIL saturate #%0d got %0d exp %0d", i, err_cnt, exp_err); end
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 96; i++) mem[i] = 8'($urandom);
        test_reset();
        test_write();
        test_read();
        test_illegal();
        test_abort();
        test_underrun();
        test_frame_edges();
        test_reset_mid();
        test_saturate();
        checks++; if (overlap !== 1'b0) begin errors++; $display("FAIL we_re_overlap got 1 exp 0"); end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/spi_cmd_ctrl.md
Name: spi_cmd_ctrl

Overview:
Command sequencer behind the byte-level SPI slave. Turns each chip-select frame into a register transaction: the first byte is an opcode and the following bytes are write data or read dummies. Drives a single-port register-file interface with address auto-increment, and prefetches read data so the SPI slave always has the next transmit byte ready.

Parameters:
ADDR_W, 7, register address width; must be ≤7 because the opcode carries the address in bits [6:0].
NUM_REGS, 96, number of implemented registers; addresses ≥NUM_REGS are illegal.
STATUS_BYTE, 8'hA5, byte presented on tx_byte when no read data is pending.

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
frame_start  in  1  one-cycle pulse: chip-select asserted
frame_end  in  1  one-cycle pulse: chip-select released
rx_valid  in  1  one-cycle pulse: rx_byte holds a complete received byte
rx_byte  in  8  received byte
tx_req  in  1  one-cycle pulse: SPI slave has loaded tx_byte into its shifter
tx_byte  out  8  next byte to transmit
reg_we  out  1  register write strobe, one cycle
reg_re  out  1  register read strobe, one cycle
reg_addr  out  ADDR_W  register address for we/re
reg_wdata  out  8  write data
reg_rdata  in  8  read data, valid exactly one cycle after reg_re
busy  out  1  high whenever state ≠ IDLE
err_cnt  out  8  saturating count of protocol errors

Behaviour:
- Reset values: all outputs 0 except tx_byte = STATUS_BYTE. State = IDLE, internal address = 0.
- States: IDLE, CMD, WR, RD_FETCH, RD_WAIT, RD_HOLD, DISCARD.
- IDLE: frame_start -> CMD. rx_valid is ignored.
- CMD: on rx_valid, decode addr = rx_byte[ADDR_W-1:0] and rw = rx_byte[7].
  - If addr ≥ NUM_REGS -> DISCARD, err_cnt+1.
  - Else if rw=0 -> WR.
  - Else rw=1 -> RD_FETCH.
- WR: each rx_valid asserts reg_we for one cycle in the next cycle, with reg_addr = current addr and reg_wdata = rx_byte; addr then increments.
- RD_FETCH: assert reg_re for one cycle with reg_addr = addr -> RD_WAIT.
- RD_WAIT: capture reg_rdata into tx_byte, addr+1 -> RD_HOLD.
- RD_HOLD: on tx_req -> RD_FETCH. rx_valid bytes are dummies and are ignored.
- Read latency: opcode rx_valid to tx_byte updated = 3 cycles.
- Address wrap: addr increments modulo NUM_REGS, so NUM_REGS-1 wraps to 0. No error is raised on wrap.
- DISCARD: ignore rx_valid and tx_req until frame_end.
- frame_end in any state -> IDLE, tx_byte = STATUS_BYTE, addr = 0. A strobe already in flight (reg_we or reg_re in the following cycle) still completes.
- Same-cycle rx_valid and frame_end: the byte is processed first (a write is still issued), then the block goes to IDLE.
- frame_start while not IDLE: abort the current transaction, err_cnt+1, go to CMD. In the same cycle, frame_end takes priority over frame_start.
- tx_req arriving in RD_FETCH or RD_WAIT: underrun, err_cnt+1. The slave sends the stale tx_byte. The fetch continues normally.
- err_cnt saturates at 8'hFF and is cleared only by reset.
- Reset mid-frame: everything returns to reset values immediately. No strobe is emitted after rst_n falls.
- reg_we and reg_re are never high in the same cycle.

Decomposition:
- Package spi_cmd_pkg holds:
  - state enum state_e;
  - opcode bit position constant OP_RW_BIT = 7;
  - function is_read(byte).
- No sub-module is needed. The error counter may be a small sat_counter instance if the codebase already has one; otherwise it is written inline.

Test Plan:
- Write burst: frame_start, rx 8'h05, 8'h11, 8'h22, 8'h33, frame_end -> reg_we three times with (addr,data) = (5,11),(6,22),(7,33); err_cnt = 0.
- Read burst: regs[10..12] = 8'hC0,C1,C2; rx 8'h8A, then 3 dummy bytes with tx_req between them -> tx_byte sequence C0,C1,C2; reg_re addresses 10,11,12; reg_we never asserted.
- Illegal address: rx 8'h70 (112 ≥ 96) followed by data bytes -> no reg_we or reg_re; err_cnt = 1; busy stays high until frame_end.
- Wrap: write opcode 8'h5F, then 2 data bytes -> writes to address 95 then address 0.
- Abort: frame_start during WR after 1 data byte, new opcode 8'h01 plus data 8'hAA -> err_cnt+1; write (1,AA); the earlier write is retained.
- Underrun and reset: tx_req 1 cycle after the read opcode -> err_cnt+1. Separately, rst_n low mid-burst -> tx_byte = A5, busy = 0, no further strobes.
